mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter for the multicycle processor's single-port unified memory (512 x 32, combinational read, write on rising clk). Port 0 is the processor's memory interface; port 1 is a secondary master (program loader / debug / DMA). The block serialises accesses with round-robin fairness, supports a short lock for atomic sequences, and returns registered read data with a one-cycle acknowledge.

## Interface
- `MAX_HOLD`, 4: maximum consecutive locked grants to one port while the other port is waiting.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `req0` / `req1`  in  1  access request; held stable, with its qualifiers, until the matching ack.
- `we0` / `we1`  in  1  1 = write, 0 = read.
- `addr0` / `addr1`  in  32  byte address, passed unmodified to memory (memory uses [31:2]).
- `wd0` / `wd1`  in  32  write data.
- `lock0` / `lock1`  in  1  request to retain ownership for the next transaction.
- `ack0` / `ack1`  out  1  one-cycle pulse: transaction complete; `rdN` valid.
- `rd0` / `rd1`  out  32  registered read data; holds its value until the next ack on that port.
- `grant`  out  2  one-hot owner during the access cycle; 00 otherwise.
- `mem_we`  out  1  memory write enable.
- `mem_a`  out  32  memory address.
- `mem_wd`  out  32  memory write data.
- `mem_rd`  in  32  memory combinational read data.

## Operation
- State register: IDLE, ACC (access), RSP (response), plus `owner` (1 bit), `last` (1 bit), and `hold` (saturating counter, width clog2(MAX_HOLD)+1).
- Arbitration takes place on the rising edge whenever the state is IDLE or RSP:
  - If the state is RSP, `lock[owner]` and `req[owner]` are both 1, and either `hold < MAX_HOLD` or the other port is idle: re-grant the owner and increment `hold` (saturating).
  - Otherwise, if only one port requests: grant it.
  - Otherwise, if both ports request: grant `!last`.
  - A new grant goes to ACC with `owner` set to the winner, `last` set to the winner, and `hold` set to 1. A lock re-grant also goes to ACC, with `owner` unchanged.
  - If no port requests: go to IDLE.
- ACC cycle:
  - `mem_a = addr[owner]`, `mem_wd = wd[owner]`, `mem_we = we[owner]`, and `grant` is one-hot for the owner.
  - On the next edge: the memory commits any write; `rd[owner] <= mem_rd` on reads only; `ack[owner] <= 1`; state goes to RSP.
- RSP cycle:
  - `ack[owner]` is high; the memory is not driven (`mem_we = 0`, `mem_a = 0`, `mem_wd = 0`, `grant = 00`).
  - The requester may drop `req` or present a new request in this cycle; arbitration runs at the end of the cycle.
- In IDLE, memory outputs are all 0.
- Writes do not update `rdN`. `rdN` for the non-owner port never changes.
- Protocol violation (`req` dropped during ACC): the transaction still completes and `ack` still pulses.

## Timing
- Reset values: state IDLE, `owner` 0, `last` 1 (so port 0 wins the first tie), `hold` 0, `ack0 = ack1 = 0`, `rd0 = rd1 = 0`, `grant = 00`, `mem_we = 0`, `mem_a = 0`, `mem_wd = 0`.
- Latency: a `req` sampled at edge E0 (from IDLE) gives ACC in cycle E0–E1 and `ack` high in cycle E1–E2.
- Throughput: at most 1 transaction per 2 cycles. Back-to-back transactions are ACC, RSP, ACC, RSP with no IDLE in between.
- Worst-case wait for a requesting port:
  - `MAX_HOLD` × 2 cycles behind a locked owner, plus 2 cycles.
  - 2 cycles behind an unlocked owner.
- Reset asserted during ACC: `mem_we` drops combinationally in the same cycle, no write commits, no ack is produced.
- Reset asserted during RSP: `ack` clears immediately.
- After reset deasserts, arbitration restarts from IDLE at the next edge.
- Simultaneous first requests after reset: port 0 wins. The tie goes to port 1 next time.
- Lock with `hold` reaching `MAX_HOLD` while the other port requests: the other port is granted at that RSP edge and `hold` resets to 1.

## Test plan
- Single read: preload RAM[5] = 0xCAFEF00D; port 0 reads addr 0x14 -> `grant = 01` one cycle later, `ack0` pulses on the following cycle, `rd0 = 0xCAFEF00D`, `rd1 = 0`.
- Write then read, port 1: write 0x12345678 to addr 0x40, then read addr 0x40 -> the write produces `mem_we = 1` for exactly 1 cycle, and the read gives `rd1 = 0x12345678`.
- Continuous contention: `req0` and `req1` both held high for 8 transactions -> grant order 0, 1, 0, 1, …; each ack spaced 2 cycles apart; neither port is starved.
- Lock limit: `lock0 = 1` with continuous `req0` while `req1` is high, `MAX_HOLD = 4` -> port 0 receives 4 consecutive grants, then port 1 is granted.
- Lock without contention: `lock0 = 1` and `req1 = 0` for 10 transactions -> port 0 is re-granted every time with no stall.
- Reset mid-write: assert `reset` during ACC of a write of 0xDEADBEEF to addr 0x8 -> RAM[2] is unchanged, all outputs are 0, and the first post-reset tie goes to port 0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two memory requesters, the arbiter and the unified memory.
// The master side drives the requests and the memory read data; the slave side is the arbiter.
interface mem_arbiter_if;
  logic        req0;
  logic        req1;
  logic        we0;
  logic        we1;
  logic        lock0;
  logic        lock1;
  logic [31:0] addr0;
  logic [31:0] addr1;
  logic [31:0] wd0;
  logic [31:0] wd1;
  logic        ack0;
  logic        ack1;
  logic [31:0] rd0;
  logic [31:0] rd1;
  logic [1:0]  grant;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  modport master (
    output req0, req1, we0, we1, lock0, lock1, addr0, addr1, wd0, wd1, mem_rd,
    input  ack0, ack1, rd0, rd1, grant, mem_we, mem_a, mem_wd
  );

  modport slave (
    input  req0, req1, we0, we1, lock0, lock1, addr0, addr1, wd0, wd1, mem_rd,
    output ack0, ack1, rd0, rd1, grant, mem_we, mem_a, mem_wd
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter for the single-port unified memory.
// Each transaction is one access cycle followed by one response cycle carrying the ack.
module mem_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam int HW = $clog2(MAX_HOLD) + 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);
  localparam logic [HW-1:0] HOLD_SAT = {HW{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RSP  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic [31:0]   rd0_q, rd0_d;
  logic [31:0]   rd1_q, rd1_d;

  logic          req_own;
  logic          req_oth;
  logic          lock_own;
  logic          we_own;
  logic [31:0]   addr_own;
  logic [31:0]   wd_own;
  logic          keep_lock;
  logic          winner;

  always_comb begin
    req_own  = owner_q ? bus.req1  : bus.req0;
    req_oth  = owner_q ? bus.req0  : bus.req1;
    lock_own = owner_q ? bus.lock1 : bus.lock0;
    we_own   = owner_q ? bus.we1   : bus.we0;
    addr_own = owner_q ? bus.addr1 : bus.addr0;
    wd_own   = owner_q ? bus.wd1   : bus.wd0;
  end

  // A locked owner keeps the memory until its streak hits MAX_HOLD, unless nobody else is waiting.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    hold_d    = hold_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    rd0_d     = rd0_q;
    rd1_d     = rd1_q;
    keep_lock = 1'b0;
    winner    = 1'b0;

    case (state_q)
      ACC: begin
        state_d = RSP;
        if (owner_q) begin
          ack1_d = 1'b1;
          if (!we_own) rd1_d = bus.mem_rd;
        end else begin
          ack0_d = 1'b1;
          if (!we_own) rd0_d = bus.mem_rd;
        end
      end
      default: begin
        keep_lock = (state_q == RSP) && lock_own && req_own &&
                    ((hold_q < HOLD_MAX) || !req_oth);
        winner    = (bus.req0 && bus.req1) ? !last_q : bus.req1;
        if (keep_lock) begin
          state_d = ACC;
          if (hold_q != HOLD_SAT) hold_d = hold_q + HOLD_ONE;
        end else if (bus.req0 || bus.req1) begin
          state_d = ACC;
          owner_d = winner;
          last_d  = winner;
          hold_d  = HOLD_ONE;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      hold_q  <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end

  // Memory is only driven in the access cycle, so a reset there kills the write at once.
  always_comb begin
    bus.grant  = 2'b00;
    bus.mem_we = 1'b0;
    bus.mem_a  = '0;
    bus.mem_wd = '0;
    if (state_q == ACC) begin
      bus.grant  = owner_q ? 2'b10 : 2'b01;
      bus.mem_we = we_own;
      bus.mem_a  = addr_own;
      bus.mem_wd = wd_own;
    end
  end

  assign bus.ack0 = ack0_q;
  assign bus.ack1 = ack1_q;
  assign bus.rd0  = rd0_q;
  assign bus.rd1  = rd1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written corner sequences,
// and random two-port traffic compared against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

  localparam int MAX_HOLD = 4;
  localparam int HOLD_SAT = (1 << ($clog2(MAX_HOLD) + 1)) - 1;

  typedef struct packed {
    logic [1:0]  grant;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        ack0;
    logic        ack1;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } out_t;

  typedef struct packed {
    logic        req0;
    logic        req1;
    logic        we0;
    logic        we1;
    logic        lock0;
    logic        lock1;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [31:0] wd0;
    logic [31:0] wd1;
  } stim_t;

  typedef struct {
    stim_t stim;
    out_t  exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   errors = 0;

  mem_arbiter_if bus ();

  mem_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Unified memory: combinational read, write on the rising edge, bulk preload on request.
  logic [31:0] ram [512];
  logic [31:0] model_ram [512];
  logic        load_en = 1'b0;
  logic [8:0]  load_idx = '0;
  logic [31:0] load_val = '0;

  function automatic logic [31:0] pattern(int i);
    return 32'h5A5A0000 ^ (32'(i) * 32'h00010003);
  endfunction

  assign bus.mem_rd = ram[bus.mem_a[10:2]];

  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < 512; i++) ram[i] <= pattern(i);
      ram[load_idx] <= load_val;
    end else if (bus.mem_we) begin
      ram[bus.mem_a[10:2]] <= bus.mem_wd;
    end
  end

  function automatic out_t dut_out();
    out_t o;
    o.grant  = bus.grant;
    o.mem_we = bus.mem_we;
    o.mem_a  = bus.mem_a;
    o.mem_wd = bus.mem_wd;
    o.ack0   = bus.ack0;
    o.ack1   = bus.ack1;
    o.rd0    = bus.rd0;
    o.rd1    = bus.rd1;
    return o;
  endfunction

  task automatic applyStimulus(input stim_t s);
    bus.req0  = s.req0;
    bus.req1  = s.req1;
    bus.we0   = s.we0;
    bus.we1   = s.we1;
    bus.lock0 = s.lock0;
    bus.lock1 = s.lock1;
    bus.addr0 = s.addr0;
    bus.addr1 = s.addr1;
    bus.wd0   = s.wd0;
    bus.wd1   = s.wd1;
  endtask

  task automatic checkOutput(input string name, input out_t exp);
    out_t act;
    act = dut_out();
    tests++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got grant=%b we=%b a=%h wd=%h ack=%b%b rd0=%h rd1=%h, want grant=%b we=%b a=%h wd=%h ack=%b%b rd0=%h rd1=%h",
               name, act.grant, act.mem_we, act.mem_a, act.mem_wd, act.ack1, act.ack0, act.rd0, act.rd1,
               exp.grant, exp.mem_we, exp.mem_a, exp.mem_wd, exp.ack1, exp.ack0, exp.rd0, exp.rd1);
    end
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Holds reset for two edges while the memory is reloaded; returns at a falling edge.
  task automatic doReset(input logic [8:0] idx, input logic [31:0] val);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus('0);
    load_idx = idx;
    load_val = val;
    load_en  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Transaction-level reference: who owns the memory, whether the access or response beat is current.
  logic        r_req [2];
  logic        r_we [2];
  logic        r_lock [2];
  logic [31:0] r_addr [2];
  logic [31:0] r_wd [2];
  logic        pend [2];
  int          m_cur;
  bit          m_acc;
  int          m_ack;
  int          m_last;
  int          m_streak;
  logic [31:0] m_rd [2];

  task automatic driveInputs();
    stim_t s;
    s.req0 = r_req[0];   s.req1 = r_req[1];
    s.we0 = r_we[0];     s.we1 = r_we[1];
    s.lock0 = r_lock[0]; s.lock1 = r_lock[1];
    s.addr0 = r_addr[0]; s.addr1 = r_addr[1];
    s.wd0 = r_wd[0];     s.wd1 = r_wd[1];
    applyStimulus(s);
  endtask

  function automatic out_t model_out();
    out_t o;
    o = '0;
    if (m_acc) begin
      o.grant  = (m_cur == 1) ? 2'b10 : 2'b01;
      o.mem_we = r_we[m_cur];
      o.mem_a  = r_addr[m_cur];
      o.mem_wd = r_wd[m_cur];
    end
    o.ack0 = (m_ack == 0);
    o.ack1 = (m_ack == 1);
    o.rd0  = m_rd[0];
    o.rd1  = m_rd[1];
    return o;
  endfunction

  task automatic model_step();
    int w;
    int o;
    w = -1;
    o = 1 - m_cur;
    if (m_acc) begin
      if (r_we[m_cur]) model_ram[r_addr[m_cur][10:2]] = r_wd[m_cur];
      else m_rd[m_cur] = model_ram[r_addr[m_cur][10:2]];
      m_ack = m_cur;
      m_acc = 1'b0;
    end else begin
      if (m_ack >= 0 && r_lock[m_cur] && r_req[m_cur] && (m_streak < MAX_HOLD || !r_req[o])) begin
        w = m_cur;
        m_streak = (m_streak >= HOLD_SAT) ? HOLD_SAT : m_streak + 1;
      end else begin
        if (r_req[0] && r_req[1]) w = (m_last == 1) ? 0 : 1;
        else if (r_req[0]) w = 0;
        else if (r_req[1]) w = 1;
        if (w >= 0) begin
          m_streak = 1;
          m_last   = w;
          m_cur    = w;
        end
      end
      m_acc = (w >= 0);
      m_ack = -1;
    end
  endtask

  vec_t vecs [8];

  initial begin
    logic [1:0] lock_seq [10];
    out_t       z;
    reset = 1'b1;
    applyStimulus('0);

    vecs[0] = '{stim: '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h14, 32'h0, 32'h0, 32'h0},
                exp:  '{2'b01, 1'b0, 32'h14, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0}};
    vecs[1] = '{stim: '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h14, 32'h0, 32'h0, 32'h0},
                exp:  '{2'b00, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'hCAFEF00D, 32'h0}};
    vecs[2] = '{stim: '0,
                exp:  '{2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'hCAFEF00D, 32'h0}};
    vecs[3] = '{stim: '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h40, 32'h0, 32'h12345678},
                exp:  '{2'b10, 1'b1, 32'h40, 32'h12345678, 1'b0, 1'b0, 32'hCAFEF00D, 32'h0}};
    vecs[4] = '{stim: '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h40, 32'h0, 32'h12345678},
                exp:  '{2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hCAFEF00D, 32'h0}};
    vecs[5] = '{stim: '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h40, 32'h0, 32'h0},
                exp:  '{2'b10, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'hCAFEF00D, 32'h0}};
    vecs[6] = '{stim: '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h40, 32'h0, 32'h0},
                exp:  '{2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hCAFEF00D, 32'h12345678}};
    vecs[7] = '{stim: '0,
                exp:  '{2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'hCAFEF00D, 32'h12345678}};
    z = '0;

    doReset(9'd5, 32'hCAFEF00D);
    checkOutput("reset_state", z);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].stim);
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Both ports requesting continuously must alternate, starting with port 0.
    doReset(9'd0, pattern(0));
    applyStimulus('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h20, 32'h0, 32'h0});
    for (int k = 0; k < 16; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k % 2 == 0) checkVal($sformatf("rr_grant%0d", k / 2), 32'(bus.grant), ((k / 2) % 2 == 1) ? 32'd2 : 32'd1);
      else checkVal($sformatf("rr_ack%0d", k / 2), 32'({bus.ack1, bus.ack0}), ((k / 2) % 2 == 1) ? 32'd2 : 32'd1);
    end

    // Locked port 0 with port 1 waiting: four grants to port 0, then port 1 gets one.
    lock_seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    doReset(9'd0, pattern(0));
    applyStimulus('{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h20, 32'h0, 32'h0});
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k % 2 == 0) checkVal($sformatf("lock_grant%0d", k / 2), 32'(bus.grant), 32'(lock_seq[k / 2]));
    end

    // Locked port 0 alone: re-granted every other cycle with no idle gap.
    doReset(9'd0, pattern(0));
    applyStimulus('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 32'h0, 32'h0});
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k % 2 == 0) checkVal($sformatf("solo_grant%0d", k / 2), 32'(bus.grant), 32'd1);
      else checkVal($sformatf("solo_ack%0d", k / 2), 32'({bus.ack1, bus.ack0}), 32'd1);
    end

    // Reset in the middle of a write access must suppress the write and clear all outputs.
    doReset(9'd2, 32'h11111111);
    applyStimulus('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8, 32'h0, 32'hDEADBEEF, 32'h0});
    @(posedge clk);
    @(negedge clk);
    checkVal("rstwr_acc_we", 32'(bus.mem_we), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("rstwr_outputs", z);
    applyStimulus('0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkVal("rstwr_ram2", ram[2], 32'h11111111);
    applyStimulus('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h20, 32'h0, 32'h0});
    @(posedge clk);
    @(negedge clk);
    checkVal("rstwr_first_tie", 32'(bus.grant), 32'd1);

    // Random traffic against the reference model.
    doReset(9'd0, pattern(0));
    for (int i = 0; i < 512; i++) model_ram[i] = pattern(i);
    for (int p = 0; p < 2; p++) begin
      r_req[p] = 1'b0; r_we[p] = 1'b0; r_lock[p] = 1'b0;
      r_addr[p] = '0;  r_wd[p] = '0;   pend[p] = 1'b0;
      m_rd[p] = '0;
    end
    m_cur = 0; m_acc = 1'b0; m_ack = -1; m_last = 1; m_streak = 0;
    driveInputs();
    for (int c = 0; c < 3000; c++) begin
      checkOutput($sformatf("rand%0d", c), model_out());
      for (int p = 0; p < 2; p++) begin
        if (m_ack == p) pend[p] = 1'b0;
        if (!pend[p] && $urandom_range(0, 3) != 0) begin
          pend[p]   = 1'b1;
          r_we[p]   = 1'($urandom_range(0, 1));
          r_addr[p] = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
          r_wd[p]   = $urandom;
          r_lock[p] = ($urandom_range(0, 2) == 0);
        end
        r_req[p] = pend[p];
      end
      driveInputs();
      model_step();
      @(posedge clk);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
